// File: rtl/pc_redirect_unit_pkg.sv
// Shared constants and helpers for the IF-stage PC redirect unit.
// Widths, PC step and FSM state encodings.
package pc_redirect_unit_pkg;

  localparam int ISA_WIDTH      = 32;
  localparam int PC_STATE_WIDTH = 2;

  localparam logic [ISA_WIDTH-1:0] PC_STEP = 32'd4;

  localparam logic [PC_STATE_WIDTH-1:0] PC_STATE_BOOT = 2'd0;
  localparam logic [PC_STATE_WIDTH-1:0] PC_STATE_RUN  = 2'd1;
  localparam logic [PC_STATE_WIDTH-1:0] PC_STATE_HOLD = 2'd2;

  function automatic logic [ISA_WIDTH-1:0] align_word(
    input logic [ISA_WIDTH-1:0] addr
  );
    return {addr[ISA_WIDTH-1:2], 2'b00};
  endfunction

endpackage

// File: rtl/pc_redirect_unit_sat_counter.sv
// Saturating up-counter: sticks at all-ones instead of wrapping.
// Synchronous active-high reset.
module sat_counter #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             inc,
  output logic [WIDTH-1:0] count
);

  always_ff @(posedge clk) begin
    if (rst)
      count <= '0;
    else if (inc && (count != {WIDTH{1'b1}}))
      count <= count + 1'b1;
  end

endmodule

// File: rtl/pc_redirect_unit.sv
// IF-stage PC owner: sequential fetch, branch/jump redirect,
// stall freeze with a held redirect, IF/ID flush and stats.
module pc_redirect_unit
  import pc_redirect_unit_pkg::*;
#(
  parameter logic [ISA_WIDTH-1:0] RESET_PC  = 32'h0000_0000,
  parameter int                   CNT_WIDTH = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 stall,
  input  logic                 branch_valid,
  input  logic                 condition_satisfied,
  input  logic [ISA_WIDTH-1:0] branch_target,
  input  logic                 jump_valid,
  input  logic [ISA_WIDTH-1:0] jump_target,
  output logic [ISA_WIDTH-1:0] pc,
  output logic [ISA_WIDTH-1:0] pc_plus_4,
  output logic                 fetch_en,
  output logic                 flush_if_id,
  output logic                 target_misaligned,
  output logic [CNT_WIDTH-1:0] branch_count,
  output logic [CNT_WIDTH-1:0] taken_count
);

  logic [PC_STATE_WIDTH-1:0] state;
  logic [PC_STATE_WIDTH-1:0] state_nxt;
  logic [ISA_WIDTH-1:0]      pending;
  logic [ISA_WIDTH-1:0]      pending_nxt;
  logic [ISA_WIDTH-1:0]      pc_nxt;
  logic [ISA_WIDTH-1:0]      sel_raw;
  logic [ISA_WIDTH-1:0]      apply_raw;
  logic                      req;
  logic                      apply;
  logic                      br_inc;

  assign req       = jump_valid | (branch_valid & condition_satisfied);
  assign sel_raw   = jump_valid ? jump_target : branch_target;
  assign pc_plus_4 = pc + PC_STEP;
  assign fetch_en  = (state != PC_STATE_BOOT);

  // Pending target is kept raw so misalignment is flagged on release.
  assign apply_raw = (state == PC_STATE_HOLD) ? pending : sel_raw;

  always_comb begin
    state_nxt   = state;
    pending_nxt = pending;
    pc_nxt      = pc;
    apply       = 1'b0;
    br_inc      = 1'b0;
    unique case (1'b1)
      (state == PC_STATE_BOOT): begin
        state_nxt = PC_STATE_RUN;
      end
      (state == PC_STATE_RUN): begin
        br_inc = branch_valid & ~stall;
        if (req && !stall) begin
          apply  = 1'b1;
          pc_nxt = align_word(sel_raw);
        end else if (req) begin
          pending_nxt = sel_raw;
          state_nxt   = PC_STATE_HOLD;
        end else if (!stall) begin
          pc_nxt = pc_plus_4;
        end
      end
      (state == PC_STATE_HOLD): begin
        if (!stall) begin
          apply     = 1'b1;
          br_inc    = branch_valid;
          pc_nxt    = align_word(pending);
          state_nxt = PC_STATE_RUN;
        end
      end
      default: begin
        state_nxt = PC_STATE_BOOT;
      end
    endcase
  end

  assign flush_if_id       = apply;
  assign target_misaligned = apply & (|apply_raw[1:0]);

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= PC_STATE_BOOT;
      pc      <= RESET_PC;
      pending <= '0;
    end else begin
      state   <= state_nxt;
      pc      <= pc_nxt;
      pending <= pending_nxt;
    end
  end

  sat_counter #(
    .WIDTH (CNT_WIDTH)
  ) u_branch_cnt (
    .clk   (clk),
    .rst   (rst),
    .inc   (br_inc),
    .count (branch_count)
  );

  sat_counter #(
    .WIDTH (CNT_WIDTH)
  ) u_taken_cnt (
    .clk   (clk),
    .rst   (rst),
    .inc   (apply),
    .count (taken_count)
  );

endmodule

// File: tb/tb_pc_redirect_unit.sv
// Directed vector bench for pc_redirect_unit.
// Inputs driven at negedge, outputs checked 1ns later.
module tb_pc_redirect_unit;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        stall = 1'b0;
  logic        branch_valid = 1'b0;
  logic        condition_satisfied = 1'b0;
  logic [31:0] branch_target = '0;
  logic        jump_valid = 1'b0;
  logic [31:0] jump_target = '0;
  logic [31:0] pc;
  logic [31:0] pc_plus_4;
  logic        fetch_en;
  logic        flush_if_id;
  logic        target_misaligned;
  logic [15:0] branch_count;
  logic [15:0] taken_count;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  pc_redirect_unit #(
    .RESET_PC  (32'h0000_0000),
    .CNT_WIDTH (16)
  ) dut (
    .clk                 (clk),
    .rst                 (rst),
    .stall               (stall),
    .branch_valid        (branch_valid),
    .condition_satisfied (condition_satisfied),
    .branch_target       (branch_target),
    .jump_valid          (jump_valid),
    .jump_target         (jump_target),
    .pc                  (pc),
    .pc_plus_4           (pc_plus_4),
    .fetch_en            (fetch_en),
    .flush_if_id         (flush_if_id),
    .target_misaligned   (target_misaligned),
    .branch_count        (branch_count),
    .taken_count         (taken_count)
  );

  typedef struct {
    logic        rst;
    logic        stall;
    logic        bv;
    logic        cs;
    logic [31:0] bt;
    logic        jv;
    logic [31:0] jt;
    logic [31:0] pc;
    logic [31:0] pp4;
    logic        fe;
    logic        fl;
    logic        mis;
    logic [15:0] bc;
    logic [15:0] tc;
  } vec_t;

  vec_t vecs[19];

  function automatic vec_t mk(
    input logic r, input logic s,
    input logic bv, input logic cs, input logic [31:0] bt,
    input logic jv, input logic [31:0] jt,
    input logic [31:0] epc, input logic [31:0] epp4,
    input logic fe, input logic fl, input logic mis,
    input logic [15:0] bc, input logic [15:0] tc
  );
    vec_t v;
    v.rst = r; v.stall = s;
    v.bv = bv; v.cs = cs; v.bt = bt;
    v.jv = jv; v.jt = jt;
    v.pc = epc; v.pp4 = epp4;
    v.fe = fe; v.fl = fl; v.mis = mis;
    v.bc = bc; v.tc = tc;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  task automatic drive(input logic r, input logic s,
                       input logic bv, input logic cs, input logic [31:0] bt,
                       input logic jv, input logic [31:0] jt);
    rst = r; stall = s;
    branch_valid = bv; condition_satisfied = cs; branch_target = bt;
    jump_valid = jv; jump_target = jt;
  endtask

  initial begin
    // rows: rst stall bv cs bt jv jt | pc pc+4 fe flush mis bc tc
    vecs[0]  = mk(1,0,0,0,0,0,0, 32'h0,32'h4, 0,0,0, 0,0);
    vecs[1]  = mk(1,0,0,0,0,0,0, 32'h0,32'h4, 0,0,0, 0,0);
    vecs[2]  = mk(1,0,0,0,0,0,0, 32'h0,32'h4, 0,0,0, 0,0);
    vecs[3]  = mk(0,0,0,0,0,0,0, 32'h0,32'h4, 0,0,0, 0,0);
    vecs[4]  = mk(0,0,0,0,0,0,0, 32'h0,32'h4, 1,0,0, 0,0);
    vecs[5]  = mk(0,0,0,0,0,0,0, 32'h4,32'h8, 1,0,0, 0,0);
    vecs[6]  = mk(0,0,0,0,0,0,0, 32'h8,32'hC, 1,0,0, 0,0);
    vecs[7]  = mk(0,0,0,0,0,0,0, 32'hC,32'h10, 1,0,0, 0,0);
    vecs[8]  = mk(0,0,1,1,32'h40,0,0, 32'h10,32'h14, 1,1,0, 0,0);
    vecs[9]  = mk(0,0,1,0,32'h99,0,0, 32'h40,32'h44, 1,0,0, 1,1);
    vecs[10] = mk(0,0,1,1,32'h80,1,32'h100, 32'h44,32'h48, 1,1,0, 2,1);
    vecs[11] = mk(0,1,1,1,32'h200,0,0, 32'h100,32'h104, 1,0,0, 3,2);
    vecs[12] = mk(0,1,1,1,32'h888,1,32'h444, 32'h100,32'h104, 1,0,0, 3,2);
    vecs[13] = mk(0,1,1,1,32'h888,1,32'h444, 32'h100,32'h104, 1,0,0, 3,2);
    vecs[14] = mk(0,0,0,0,0,0,0, 32'h100,32'h104, 1,1,0, 3,2);
    vecs[15] = mk(0,0,0,0,0,1,32'h203, 32'h200,32'h204, 1,1,1, 3,3);
    vecs[16] = mk(0,0,0,0,0,1,32'hFFFF_FFFC, 32'h200,32'h204, 1,1,0, 3,4);
    vecs[17] = mk(0,0,0,0,0,0,0, 32'hFFFF_FFFC,32'h0, 1,0,0, 3,5);
    vecs[18] = mk(0,0,0,0,0,0,0, 32'h0,32'h4, 1,0,0, 3,5);

    for (int i = 0; i < 19; i++) begin
      @(negedge clk);
      drive(vecs[i].rst, vecs[i].stall, vecs[i].bv, vecs[i].cs,
            vecs[i].bt, vecs[i].jv, vecs[i].jt);
      #1;
      chk($sformatf("v%0d pc", i), pc, vecs[i].pc);
      chk($sformatf("v%0d pc_plus_4", i), pc_plus_4, vecs[i].pp4);
      chk($sformatf("v%0d fetch_en", i), 32'(fetch_en), 32'(vecs[i].fe));
      chk($sformatf("v%0d flush", i), 32'(flush_if_id), 32'(vecs[i].fl));
      chk($sformatf("v%0d misaligned", i), 32'(target_misaligned),
          32'(vecs[i].mis));
      chk($sformatf("v%0d branch_count", i), 32'(branch_count),
          32'(vecs[i].bc));
      chk($sformatf("v%0d taken_count", i), 32'(taken_count),
          32'(vecs[i].tc));
    end

    // Saturation: 65538 back-to-back jumps on top of 5 prior redirects
    for (int i = 0; i < 65538; i++) begin
      @(negedge clk);
      drive(0, 0, 0, 0, 0, 1, 32'h300);
    end
    @(negedge clk);
    drive(0, 0, 0, 0, 0, 0, 0);
    #1;
    chk("sat taken_count", 32'(taken_count), 32'hFFFF);
    chk("sat branch_count", 32'(branch_count), 32'd3);
    chk("sat pc", pc, 32'h300);

    // Reset while a redirect is pending in HOLD
    @(negedge clk);
    drive(0, 1, 1, 1, 32'h500, 0, 0);
    #1;
    chk("hold entry flush", 32'(flush_if_id), 32'd0);
    @(negedge clk);
    drive(0, 1, 0, 0, 0, 0, 0);
    #1;
    chk("hold pc frozen", pc, 32'h304);
    @(negedge clk);
    drive(1, 1, 0, 0, 0, 0, 0);
    @(negedge clk);
    drive(0, 0, 0, 0, 0, 0, 0);
    #1;
    chk("rst hold pc", pc, 32'h0);
    chk("rst hold fetch_en", 32'(fetch_en), 32'd0);
    chk("rst hold flush", 32'(flush_if_id), 32'd0);
    chk("rst hold taken_count", 32'(taken_count), 32'd0);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      #1;
      chk($sformatf("post rst pc%0d", i), pc, 32'(i * 4));
      chk($sformatf("post rst flush%0d", i), 32'(flush_if_id), 32'd0);
      chk($sformatf("post rst fetch%0d", i), 32'(fetch_en), 32'd1);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/pc_redirect_unit.md
# pc_redirect_unit

IF-stage program-counter owner for the pipelined CPU. Consumes the ID-stage branch decision (`condition_satisfied` from the branch comparator) together with the branch/jump target, and steps the PC: sequential fetch, redirect on a taken branch or jump, and freeze under hazard stall. A redirect that arrives during a stall is held until the stall releases. Also drives the IF/ID flush and keeps saturating branch statistics.

## Interface
Parameters:
- `RESET_PC`, default `32'h0000_0000`: PC value loaded on reset.
- `CNT_WIDTH`, default 16: width of the statistics counters.

Ports:
- `clk`  in  1  system clock; all state updates on the rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `stall`  in  1  hazard-unit freeze of IF and ID.
- `branch_valid`  in  1  the ID instruction is a conditional branch.
- `condition_satisfied`  in  1  branch condition result from ID.
- `branch_target`  in  `ISA_WIDTH`  conditional-branch target.
- `jump_valid`  in  1  the ID instruction is an unconditional jump (j/jal/jr).
- `jump_target`  in  `ISA_WIDTH`  jump target.
- `pc`  out  `ISA_WIDTH`  current fetch address (registered).
- `pc_plus_4`  out  `ISA_WIDTH`  `pc + 4`, modulo 2^32 (combinational).
- `fetch_en`  out  1  instruction-memory read enable.
- `flush_if_id`  out  1  loads a bubble into IF/ID at the next edge.
- `target_misaligned`  out  1  one-cycle pulse: the applied target had nonzero bits [1:0].
- `branch_count`  out  `CNT_WIDTH`  conditional branches resolved.
- `taken_count`  out  `CNT_WIDTH`  redirects applied (branches and jumps).

## Operation
States:
- BOOT: entered on reset.
- RUN: normal operation.
- HOLD: a redirect is pending behind a stall.

Redirect request: `req = jump_valid | (branch_valid & condition_satisfied)`. If both sources are active, the jump target wins.

Target alignment: the applied target always has bits [1:0] forced to 0. When the raw target had nonzero bits [1:0], `target_misaligned` pulses in the cycle the target is applied.

Reset: `pc=RESET_PC`, state BOOT, `fetch_en=0`, `flush_if_id=0`, `target_misaligned=0`, both counters 0, pending register 0.

BOOT:
- `fetch_en=0`, `pc` holds.
- Moves to RUN unconditionally after one cycle.

RUN (`fetch_en=1`):
- `req & ~stall`: `pc <= target`, `flush_if_id=1` this cycle, `taken_count++`.
- `req & stall`: latch the selected target into the pending register and go to HOLD. `pc` holds, no flush.
- `~req & ~stall`: `pc <= pc_plus_4`.
- `~req & stall`: `pc` holds.
- `branch_count++` when `branch_valid & ~stall`.

HOLD (`fetch_en=1`):
- ID is frozen, so new `req` inputs are ignored.
- While `stall`: everything holds.
- When `~stall`: `pc <= pending`, `flush_if_id=1`, `taken_count++`, go to RUN.
- On that release, `branch_count++` if `branch_valid` is high.

Counters saturate at all-ones and never wrap.

`pc_plus_4` wraps: `32'hFFFF_FFFC` becomes `0`.

A reset asserted in any state, including HOLD, discards the pending redirect and returns to BOOT.

## Timing
- `pc`, state and counters are registered.
- `flush_if_id`, `target_misaligned` and `pc_plus_4` are combinational from current inputs and state.
- Redirect latency is 1 cycle: a request at cycle N with no stall gives `pc=target` in cycle N+1. The wrong-path instruction fetched in cycle N is squashed by `flush_if_id` high in cycle N.
- Stalled redirect: target applied one cycle after the first cycle with `stall=0`. Flush is asserted in that release cycle.
- First fetch after reset deassertion: `fetch_en` goes high 1 cycle after BOOT, at `pc=RESET_PC`.
- `flush_if_id` lasts exactly one cycle per applied redirect. It is never asserted in BOOT or while stalled.

## Structure
- Shared constants belong in `definitions.v`:
  - `ISA_WIDTH`
  - a `PC_STEP` constant equal to 4
  - `PC_STATE_WIDTH` and the state encodings `PC_STATE_BOOT`, `PC_STATE_RUN`, `PC_STATE_HOLD`
- `RESET_PC` stays a module parameter.
- One natural sub-module, `sat_counter`: a parameterized-width saturating counter with `clk`, `rst` and `inc`. It is instantiated twice, for `branch_count` and `taken_count`.
- Target selection and alignment stay inline.

## Test plan
- **Reset and boot:** hold `rst` 3 cycles, then release with no requests. Required: `fetch_en=0` for one cycle, then `pc` runs 0, 4, 8, 12.
- **Taken branch:** at `pc=0x10`, apply `branch_valid=1`, `condition_satisfied=1`, `branch_target=0x40`. Required: `flush_if_id=1` that cycle, `pc=0x40` next cycle, `taken_count=1`, `branch_count=1`.
- **Not-taken branch, then jump priority:**
  - Not-taken (`condition_satisfied=0`): `pc` advances by 4, no flush, `branch_count` increments.
  - Then `jump_valid=1` (target `0x100`) together with a taken branch (target `0x80`): `pc=0x100`.
- **Redirect under stall:** branch taken to `0x200` with `stall=1` for 3 cycles; inputs change to garbage from the second cycle. Required: `pc` frozen, no flush during the stall; `pc=0x200` one cycle after stall drops, with a single flush pulse.
- **Misalignment and wrap:**
  - Jump to `0x203`: `pc=0x200` and `target_misaligned` pulses.
  - Sequential fetch from `0xFFFF_FFFC`: next `pc=0`.
- **Saturation and reset in HOLD:**
  - Force 2^16+2 taken redirects: `taken_count=16'hFFFF`.
  - Assert `rst` while in HOLD: `pc=RESET_PC`, pending redirect never applied.
